// File: rtl/id_ex_pipe_reg_if.sv
// Purpose : one pipeline-stage slot (decoded instruction + operands + forwarding selects),
//           used on both the ID-side input and the EX-side output of the ID/EX register.
// Latency : n/a (wires only).
// Backpressure : none carried here; stall/flush/resume travel as scalar ports.
// Port summary: valid, op, funct, rs, rt, rd, shamt, imm, rs_data, rt_data, pc4, fwd.
//   master = the side that drives the slot, slave = the side that consumes it.
interface id_ex_pipe_reg_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          valid;
    logic [5:0]    op;
    logic [5:0]    funct;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [4:0]    shamt;
    logic [DW-1:0] imm;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] pc4;
    logic [5:0]    fwd;     // {ALUaeq,ALUbeq,MEMaeq,MEMbeq,rfd2alueq,rfd2dmeq}

    modport master (
        output valid, op, funct, rs, rt, rd, shamt, imm, rs_data, rt_data, pc4, fwd
    );
    modport slave (
        input  valid, op, funct, rs, rt, rd, shamt, imm, rs_data, rt_data, pc4, fwd
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// Purpose : ID/EX pipeline register; inserts NOP bubbles on stall/flush, freezes on halting syscall.
// Latency : 1 cycle from id slot to ex slot.
// Backpressure : stall/flush replace the captured instruction with a bubble; HALTED ignores ID until resume.
// Ports   : clk, rst (sync, active-high), id (slot in, slave), ex (slot out, master),
//           stall, flush, resume, halted, bubble_cnt, flush_cnt.
// Option  : PERF_CNT_EN enables saturating bubble/flush counters; otherwise both read 16'h0.
module id_ex_pipe_reg #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    id_ex_pipe_reg_if.slave       id,
    id_ex_pipe_reg_if.master      ex,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  resume,
    output logic                  halted,
    output logic [15:0]           bubble_cnt,
    output logic [15:0]           flush_cnt
);

    typedef struct packed {
        logic          valid;
        logic [5:0]    op;
        logic [5:0]    funct;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [4:0]    shamt;
        logic [DW-1:0] imm;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] pc4;
        logic [5:0]    fwd;
    } stage_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t state;
    stage_t ex_q;
    stage_t id_s;
    logic   halt_hit;

    // Slot as it would be captured; an empty slot carries no forwarding request.
    always_comb begin
        id_s.valid   = id.valid;
        id_s.op      = id.op;
        id_s.funct   = id.funct;
        id_s.rs      = id.rs;
        id_s.rt      = id.rt;
        id_s.rd      = id.rd;
        id_s.shamt   = id.shamt;
        id_s.imm     = id.imm;
        id_s.rs_data = id.rs_data;
        id_s.rt_data = id.rt_data;
        id_s.pc4     = id.pc4;
        id_s.fwd     = id.valid ? id.fwd : 6'h0;
    end

    // Halting syscall: the instruction currently in EX is a syscall with v0 == 10.
    assign halt_hit = ex_q.valid && (ex_q.op == 6'h00) && (ex_q.funct == 6'h0c)
                      && (ex_q.rs_data == DW'(10));

    // A bubble is the all-zero slot: sll $0,$0,0 with dest $0 and no forwarding.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            ex_q  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_hit) begin
                        state <= HALTED;
                        ex_q  <= '0;
                    end else if (flush || stall) begin
                        ex_q  <= '0;
                    end else begin
                        ex_q  <= id_s;
                    end
                end
                HALTED: begin
                    ex_q <= '0;
                    if (resume) begin
                        state <= RUN;
                    end
                end
            endcase
        end
    end

    assign halted     = (state == HALTED);

    assign ex.valid   = ex_q.valid;
    assign ex.op      = ex_q.op;
    assign ex.funct   = ex_q.funct;
    assign ex.rs      = ex_q.rs;
    assign ex.rt      = ex_q.rt;
    assign ex.rd      = ex_q.rd;
    assign ex.shamt   = ex_q.shamt;
    assign ex.imm     = ex_q.imm;
    assign ex.rs_data = ex_q.rs_data;
    assign ex.rt_data = ex_q.rt_data;
    assign ex.pc4     = ex_q.pc4;
    assign ex.fwd     = ex_q.fwd;

`ifdef PERF_CNT_EN
    logic [15:0] bubble_q;
    logic [15:0] flush_q;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_q <= 16'h0;
            flush_q  <= 16'h0;
        end else if (state == RUN) begin
            if (flush && (flush_q != 16'hffff)) begin
                flush_q <= flush_q + 16'h1;
            end
            if (stall && !flush && (bubble_q != 16'hffff)) begin
                bubble_q <= bubble_q + 16'h1;
            end
        end
    end

    assign bubble_cnt = bubble_q;
    assign flush_cnt  = flush_q;
`else
    assign bubble_cnt = 16'h0;
    assign flush_cnt  = 16'h0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Purpose : directed self-checking bench for id_ex_pipe_reg.
// Latency : checks taken 1 time unit after each rising edge; inputs changed at the same point.
// Backpressure : exercises stall, flush, halt/resume and counter saturation.
module tb_id_ex_pipe_reg;

`ifdef PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        resume;
    logic        halted;
    logic [15:0] bubble_cnt;
    logic [15:0] flush_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    id_ex_pipe_reg_if #(.DW(32), .RW(5)) id_bus ();
    id_ex_pipe_reg_if #(.DW(32), .RW(5)) ex_bus ();

    id_ex_pipe_reg #(.DW(32), .RW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .id         (id_bus),
        .ex         (ex_bus),
        .stall      (stall),
        .flush      (flush),
        .resume     (resume),
        .halted     (halted),
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
    );

    always #5 clk = ~clk;

    logic [166:0] ex_all;
    assign ex_all = {ex_bus.valid, ex_bus.op, ex_bus.funct, ex_bus.rs, ex_bus.rt, ex_bus.rd,
                     ex_bus.shamt, ex_bus.imm, ex_bus.rs_data, ex_bus.rt_data, ex_bus.pc4,
                     ex_bus.fwd};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [5:0] op, input logic [5:0] funct,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rs_data, input logic [5:0] fwd);
        id_bus.valid   = v;
        id_bus.op      = op;
        id_bus.funct   = funct;
        id_bus.rs      = rs;
        id_bus.rt      = rt;
        id_bus.rd      = rd;
        id_bus.shamt   = 5'd0;
        id_bus.imm     = 32'h0000_1234;
        id_bus.rs_data = rs_data;
        id_bus.rt_data = 32'h0000_0007;
        id_bus.pc4     = 32'h0000_0104;
        id_bus.fwd     = fwd;
    endtask

    task automatic test_reset;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; resume = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_id(1'b1, 6'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                   $urandom, 6'($urandom));
            step();
            n_cmp++;
            if (ex_all !== '0) begin
                n_fail++; $display("FAIL reset_ex[%0d]: got %h want 0", i, ex_all);
            end
            n_cmp++;
            if (halted !== 1'b0) begin
                n_fail++; $display("FAIL reset_halted[%0d]: got %b want 0", i, halted);
            end
            n_cmp++;
            if ({bubble_cnt, flush_cnt} !== 32'h0) begin
                n_fail++; $display("FAIL reset_cnt[%0d]: got %h want 0", i, {bubble_cnt, flush_cnt});
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_stream;
        set_id(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 6'b101001);
        step();
        n_cmp++;
        if ({ex_bus.valid, ex_bus.rd, ex_bus.funct, ex_bus.fwd} !== {1'b1, 5'd3, 6'h20, 6'b101001}) begin
            n_fail++; $display("FAIL stream_add: got v%b rd%0d f%h fwd%b want v1 rd3 f20 fwd101001",
                               ex_bus.valid, ex_bus.rd, ex_bus.funct, ex_bus.fwd);
        end
        n_cmp++;
        if ({ex_bus.rs_data, ex_bus.pc4, ex_bus.imm} !== {32'd5, 32'h104, 32'h1234}) begin
            n_fail++; $display("FAIL stream_data: got %h %h %h want 5 104 1234",
                               ex_bus.rs_data, ex_bus.pc4, ex_bus.imm);
        end
        // Empty ID slot: fields captured, forwarding suppressed.
        set_id(1'b0, 6'h00, 6'h22, 5'd4, 5'd5, 5'd7, 32'd9, 6'h3f);
        step();
        n_cmp++;
        if ({ex_bus.valid, ex_bus.fwd, ex_bus.rd} !== {1'b0, 6'h00, 5'd7}) begin
            n_fail++; $display("FAIL stream_invalid: got v%b fwd%h rd%0d want v0 fwd00 rd7",
                               ex_bus.valid, ex_bus.fwd, ex_bus.rd);
        end
    endtask

    task automatic test_stall;
        set_id(1'b1, 6'h23, 6'h00, 5'd1, 5'd4, 5'd0, 32'd100, 6'b000010);
        step();
        n_cmp++;
        if ({ex_bus.valid, ex_bus.op, ex_bus.rt} !== {1'b1, 6'h23, 5'd4}) begin
            n_fail++; $display("FAIL stall_lw: got v%b op%h rt%0d want v1 op23 rt4",
                               ex_bus.valid, ex_bus.op, ex_bus.rt);
        end
        set_id(1'b1, 6'h00, 6'h20, 5'd4, 5'd2, 5'd3, 32'd5, 6'b100000);
        stall = 1'b1;
        step();
        n_cmp++;
        if (ex_all !== '0) begin
            n_fail++; $display("FAIL stall_bubble: got %h want 0", ex_all);
        end
        n_cmp++;
        if (bubble_cnt !== 16'(PERF)) begin
            n_fail++; $display("FAIL stall_cnt: got %0d want %0d", bubble_cnt, PERF);
        end
        stall = 1'b0;
        step();
        n_cmp++;
        if ({ex_bus.valid, ex_bus.rd, ex_bus.fwd} !== {1'b1, 5'd3, 6'b100000}) begin
            n_fail++; $display("FAIL stall_release: got v%b rd%0d fwd%b want v1 rd3 fwd100000",
                               ex_bus.valid, ex_bus.rd, ex_bus.fwd);
        end
    endtask

    task automatic test_stall_flush;
        stall = 1'b1; flush = 1'b1;
        step();
        n_cmp++;
        if (ex_all !== '0) begin
            n_fail++; $display("FAIL sf_bubble: got %h want 0", ex_all);
        end
        n_cmp++;
        if ({bubble_cnt, flush_cnt} !== {16'(PERF), 16'(PERF)}) begin
            n_fail++; $display("FAIL sf_cnt: got b%0d f%0d want b%0d f%0d",
                               bubble_cnt, flush_cnt, PERF, PERF);
        end
        stall = 1'b0;
        step();
        n_cmp++;
        if ({ex_bus.valid, bubble_cnt, flush_cnt} !== {1'b0, 16'(PERF), 16'(2 * PERF)}) begin
            n_fail++; $display("FAIL flush_only: got v%b b%0d f%0d want v0 b%0d f%0d",
                               ex_bus.valid, bubble_cnt, flush_cnt, PERF, 2 * PERF);
        end
        flush = 1'b0;
    endtask

    task automatic test_halt;
        set_id(1'b1, 6'h00, 6'h0c, 5'd2, 5'd0, 5'd0, 32'd10, 6'b000000);
        step();
        n_cmp++;
        if ({ex_bus.valid, ex_bus.funct, halted} !== {1'b1, 6'h0c, 1'b0}) begin
            n_fail++; $display("FAIL halt_syscall_ex: got v%b f%h h%b want v1 f0c h0",
                               ex_bus.valid, ex_bus.funct, halted);
        end
        set_id(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd9, 32'd5, 6'b010000);
        step();
        n_cmp++;
        if ({halted, ex_all} !== {1'b1, 167'h0}) begin
            n_fail++; $display("FAIL halt_enter: got h%b ex%h want h1 ex0", halted, ex_all);
        end
        stall = 1'b1; flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if ({halted, ex_bus.valid} !== 2'b10) begin
                n_fail++; $display("FAIL halt_hold[%0d]: got h%b v%b want h1 v0", i, halted, ex_bus.valid);
            end
        end
        n_cmp++;
        if ({bubble_cnt, flush_cnt} !== {16'(PERF), 16'(2 * PERF)}) begin
            n_fail++; $display("FAIL halt_nocount: got b%0d f%0d want b%0d f%0d",
                               bubble_cnt, flush_cnt, PERF, 2 * PERF);
        end
        stall = 1'b0; flush = 1'b0; resume = 1'b1;
        step();
        n_cmp++;
        if ({halted, ex_bus.valid} !== 2'b00) begin
            n_fail++; $display("FAIL resume_edge: got h%b v%b want h0 v0", halted, ex_bus.valid);
        end
        resume = 1'b0;
        step();
        n_cmp++;
        if ({ex_bus.valid, ex_bus.rd, halted} !== {1'b1, 5'd9, 1'b0}) begin
            n_fail++; $display("FAIL resume_capture: got v%b rd%0d h%b want v1 rd9 h0",
                               ex_bus.valid, ex_bus.rd, halted);
        end
        // Resume while running changes nothing.
        set_id(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd5, 32'd5, 6'b000000);
        resume = 1'b1;
        step();
        resume = 1'b0;
        n_cmp++;
        if ({ex_bus.valid, ex_bus.rd, halted} !== {1'b1, 5'd5, 1'b0}) begin
            n_fail++; $display("FAIL resume_in_run: got v%b rd%0d h%b want v1 rd5 h0",
                               ex_bus.valid, ex_bus.rd, halted);
        end
    endtask

    task automatic test_no_halt;
        set_id(1'b1, 6'h00, 6'h0c, 5'd2, 5'd0, 5'd0, 32'd1, 6'b000000);
        step();
        set_id(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd6, 32'd5, 6'b000000);
        step();
        n_cmp++;
        if ({halted, ex_bus.valid, ex_bus.rd} !== {1'b0, 1'b1, 5'd6}) begin
            n_fail++; $display("FAIL no_halt: got h%b v%b rd%0d want h0 v1 rd6",
                               halted, ex_bus.valid, ex_bus.rd);
        end
    endtask

    task automatic test_saturate;
        stall = 1'b1;
`ifdef PERF_CNT_EN
        for (int i = 0; i < 70000; i++) step();
        n_cmp++;
        if (bubble_cnt !== 16'hffff) begin
            n_fail++; $display("FAIL bubble_saturate: got %h want ffff", bubble_cnt);
        end
`else
        for (int i = 0; i < 50; i++) step();
        n_cmp++;
        if ({bubble_cnt, flush_cnt} !== 32'h0) begin
            n_fail++; $display("FAIL counters_disabled: got %h want 0", {bubble_cnt, flush_cnt});
        end
`endif
        n_cmp++;
        if (ex_all !== '0) begin
            n_fail++; $display("FAIL long_stall_bubble: got %h want 0", ex_all);
        end
        stall = 1'b0;
    endtask

    task automatic test_reset_mid_halt;
        set_id(1'b1, 6'h00, 6'h0c, 5'd2, 5'd0, 5'd0, 32'd10, 6'b000000);
        step();
        step();
        n_cmp++;
        if (halted !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_halt: got %b want 1", halted);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({halted, bubble_cnt, flush_cnt, ex_all} !== '0) begin
            n_fail++; $display("FAIL reset_mid_halt: got h%b b%0d f%0d ex%h want all 0",
                               halted, bubble_cnt, flush_cnt, ex_all);
        end
        set_id(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd8, 32'd5, 6'b000000);
        step();
        n_cmp++;
        if ({ex_bus.valid, ex_bus.rd} !== {1'b1, 5'd8}) begin
            n_fail++; $display("FAIL post_reset_run: got v%b rd%0d want v1 rd8", ex_bus.valid, ex_bus.rd);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; resume = 1'b0;
        set_id(1'b0, 6'h0, 6'h0, 5'd0, 5'd0, 5'd0, 32'd0, 6'h0);
        #2;
        test_reset();
        test_stream();
        test_stall();
        test_stall_flush();
        test_halt();
        test_no_halt();
        test_saturate();
        test_reset_mid_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
